// File: rtl/xadc_multi_monitor.sv
// Multi-channel XADC threshold monitor: sweeps N_CH aux channels over DRP, keeps per-channel results and sticky flags.
// Optional build macro XADC_AVG_EN: four back-to-back reads per channel, RESULT = truncated average.
module xadc_multi_monitor #(
  parameter int         N_CH        = 4,
  parameter logic [6:0] BASE_ADDR   = 7'h12,
  parameter int         DATA_W      = 12,
  parameter int         TIMEOUT_CYC = 255,
  parameter int         ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_we,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              drp_den,
  output logic [6:0]        drp_daddr,
  output logic              drp_dwe,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  input  logic              eos_in,
  output logic              irq
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CMP, S_DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [TMR_W-1:0]  timer;
  logic              cont;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [N_CH-1:0]   flags;
  logic [DATA_W-1:0] thr    [N_CH];
  logic [DATA_W-1:0] result [N_CH];

`ifdef XADC_AVG_EN
  logic [DATA_W+1:0] acc;
  logic [1:0]        rd_cnt;
  logic [DATA_W+1:0] acc_sum;
`endif

  logic              ctrl_wr;
  logic              flags_wr;
  logic              start_req;
  logic              last_ch;
  logic [DATA_W-1:0] sample;
  logic              unused_bits;

  assign ctrl_wr     = bus_we && (bus_addr == ADDR_W'(0));
  assign flags_wr    = bus_we && (bus_addr == ADDR_W'(1));
  assign start_req   = ctrl_wr && bus_wdata[0];
  assign last_ch     = (ch == CH_W'(N_CH - 1));
  assign sample      = drp_do[15 -: DATA_W];
  assign drp_dwe     = 1'b0;
  assign unused_bits = ^{bus_wdata, drp_do};

`ifdef XADC_AVG_EN
  assign acc_sum = acc + {2'b00, sample};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      timer     <= '0;
      cont      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      flags     <= '0;
      drp_den   <= 1'b0;
      drp_daddr <= BASE_ADDR;
      irq       <= 1'b0;
      // NOTE: THR/RESULT are flop arrays, not RAM; software expects defined values straight out of reset.
      for (int k = 0; k < N_CH; k++) begin
        thr[k]    <= '1;
        result[k] <= '0;
      end
`ifdef XADC_AVG_EN
      acc    <= '0;
      rd_cnt <= '0;
`endif
    end else begin
      drp_den <= 1'b0;
      irq     <= 1'b0;

      // NOTE: bus clears come first; a later nonblocking set of the same bit in this block wins, so set beats W1C.
      if (ctrl_wr) begin
        cont <= bus_wdata[1];
        if (bus_wdata[3]) done    <= 1'b0;
        if (bus_wdata[4]) timeout <= 1'b0;
      end
      if (flags_wr) flags <= flags & ~bus_wdata[N_CH-1:0];
      for (int k = 0; k < N_CH; k++) begin
        if (bus_we && (bus_addr == ADDR_W'(2 + k))) thr[k] <= bus_wdata[DATA_W-1:0];
      end

      case (state)
        S_IDLE: begin
          if (start_req || (cont && eos_in)) begin
            ch    <= '0;
            busy  <= 1'b1;
            state <= S_REQ;
          end
        end

        S_REQ: begin
          drp_den   <= 1'b1;
          drp_daddr <= BASE_ADDR + 7'(ch);
          timer     <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          if (drp_drdy) begin
`ifdef XADC_AVG_EN
            if (rd_cnt == 2'd3) begin
              result[ch] <= acc_sum[DATA_W+1:2];
              rd_cnt     <= '0;
              state      <= S_CMP;
            end else begin
              acc    <= (rd_cnt == 2'd0) ? {2'b00, sample} : acc_sum;
              rd_cnt <= rd_cnt + 2'd1;
              state  <= S_REQ;
            end
`else
            result[ch] <= sample;
            state      <= S_CMP;
`endif
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            // Abandon the channel: no compare, result keeps its previous value.
            timeout <= 1'b1;
`ifdef XADC_AVG_EN
            rd_cnt  <= '0;
`endif
            if (last_ch) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + 1'b1;
              state <= S_REQ;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_CMP: begin
          if (result[ch] >= thr[ch]) flags[ch] <= 1'b1;
          if (last_ch) begin
            state <= S_DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_REQ;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          irq   <= |flags;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_addr == ADDR_W'(0)) begin
      bus_rdata[4:0] = {timeout, done, busy, cont, 1'b0};
    end else if (bus_addr == ADDR_W'(1)) begin
      bus_rdata[N_CH-1:0] = flags;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (bus_addr == ADDR_W'(2 + k))        bus_rdata[DATA_W-1:0] = thr[k];
      if (bus_addr == ADDR_W'(2 + N_CH + k)) bus_rdata[DATA_W-1:0] = result[k];
    end
  end

endmodule

// File: tb/tb_xadc_multi_monitor.sv
// Self-checking bench for xadc_multi_monitor: DRP responder model, address scoreboard, register-level result checks.
module tb_xadc_multi_monitor;

  localparam int         N_CH   = 4;
  localparam logic [6:0] BASE   = 7'h12;
  localparam int         DATA_W = 12;
  localparam int         ADDR_W = 6;
`ifdef XADC_AVG_EN
  localparam int NRD = 4;
`else
  localparam int NRD = 1;
`endif

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              drp_den;
  logic [6:0]        drp_daddr;
  logic              drp_dwe;
  logic [15:0]       drp_do;
  logic              drp_drdy;
  logic              eos_in;
  logic              irq;

  xadc_multi_monitor #(
    .N_CH(N_CH), .BASE_ADDR(BASE), .DATA_W(DATA_W), .TIMEOUT_CYC(255), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .eos_in(eos_in), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int irq_cnt = 0;
  always @(negedge clk) if (irq === 1'b1) irq_cnt++;

  // DRP responder and expected-address scoreboard
  logic [15:0]       rsp_data [N_CH];
  logic [N_CH-1:0]   mute;
  int                rsp_delay = 2;
  logic [6:0]        exp_addr_q [$];
  int                den_cnt = 0;
  int                first_den [N_CH];
  int                rd_k = 0;
  int                prev_ch = -1;
  int                rsp_c;

  initial begin
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (!rst) begin
        rd_k    = 0;
        prev_ch = -1;
      end else if (drp_den === 1'b1) begin
        den_cnt++;
        if (exp_addr_q.size() == 0) check("den_unexpected", 32'(drp_daddr), 32'hFFFF_FFFF);
        else check("daddr", 32'(drp_daddr), 32'(exp_addr_q.pop_front()));
        rsp_c = int'(drp_daddr) - int'(BASE);
        if (rsp_c < 0 || rsp_c >= N_CH) rsp_c = 0;
        if (rsp_c != prev_ch) rd_k = 0;
        if (rd_k == 0) first_den[rsp_c] = cyc;
        prev_ch = rsp_c;
        if (!mute[rsp_c]) begin
          repeat (rsp_delay) @(negedge clk);
          if (rst) begin
            drp_do   = 16'(rsp_data[rsp_c] + 16'(rd_k * 16));
            drp_drdy = 1'b1;
          end
        end
        rd_k++;
      end
    end
  end

  // Reference model of the register file
  logic [DATA_W-1:0] exp_result [N_CH];
  logic [DATA_W-1:0] thr_m      [N_CH];
  logic [N_CH-1:0]   exp_flags;

  function automatic logic [DATA_W-1:0] model_res(input int c);
    int          sum;
    logic [15:0] d;
    sum = 0;
    for (int k = 0; k < NRD; k++) begin
      d   = 16'(rsp_data[c] + 16'(k * 16));
      sum += int'(d[15:4]);
    end
    return DATA_W'(sum / NRD);
  endfunction

  task automatic push_sweep();
    for (int c = 0; c < N_CH; c++) begin
      repeat (mute[c] ? 1 : NRD) exp_addr_q.push_back(BASE + 7'(c));
      if (!mute[c]) begin
        exp_result[c] = model_res(c);
        if (exp_result[c] >= thr_m[c]) exp_flags[c] = 1'b1;
      end
    end
  endtask

  task automatic bus_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    bus_addr  = ADDR_W'(addr);
    bus_wdata = data;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [31:0] data);
    @(negedge clk);
    bus_addr = ADDR_W'(addr);
    #1;
    data = bus_rdata;
  endtask

  task automatic write_thr(input int c, input logic [DATA_W-1:0] v);
    bus_write(2 + c, 32'(v));
    thr_m[c] = v;
  endtask

  task automatic eos_pulse();
    @(negedge clk);
    eos_in = 1'b1;
    @(negedge clk);
    eos_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    logic [31:0] d;
    int          n;
    n = 0;
    bus_read(0, d);
    while (d[2] && n < limit) begin
      bus_read(0, d);
      n++;
    end
    check({tag, "_idle"}, 32'(d[2]), 32'd0);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    for (int c = 0; c < N_CH; c++) begin
      bus_read(2 + N_CH + c, d);
      check($sformatf("%s_result%0d", tag, c), d, 32'(exp_result[c]));
    end
    bus_read(1, d);
    check({tag, "_flags"}, d, 32'(exp_flags));
    check({tag, "_queue"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          wr_cyc;
    int          irq_base;
    int          den_base;

    rst = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; eos_in = 1'b0; mute = '0;
    exp_flags = '0;
    for (int c = 0; c < N_CH; c++) begin
      rsp_data[c] = '0; thr_m[c] = '1; exp_result[c] = '0; first_den[c] = -1000;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_den", 32'(drp_den), 32'd0);
    check("rst_daddr", 32'(drp_daddr), 32'h12);
    check("rst_dwe", 32'(drp_dwe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    bus_read(0, d);
    check("rst_ctrl", d, 32'd0);
    for (int c = 0; c < N_CH; c++) begin
      bus_read(2 + c, d);
      check($sformatf("rst_thr%0d", c), d, 32'hFFF);
    end
    check_regs("rst");
    bus_read(40, d);
    check("unmapped", d, 32'd0);

    // Basic sweep, start latency, address order, flags and irq
    write_thr(1, 12'h800);
    rsp_data[0] = 16'h1230; rsp_data[1] = 16'h9000; rsp_data[2] = 16'h0010; rsp_data[3] = 16'hFFF0;
    irq_base = irq_cnt;
    push_sweep();
    @(negedge clk);
    wr_cyc    = cyc;
    bus_addr  = ADDR_W'(0);
    bus_wdata = 32'h1;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
    wait_idle("sweep", 400);
    check("start_lat", 32'(first_den[0] - wr_cyc), 32'd2);
    check_regs("sweep");
`ifndef XADC_AVG_EN
    bus_read(2 + N_CH + 1, d);
    check("sweep_res1_lit", d, 32'h900);
    bus_read(1, d);
    check("sweep_flags_lit", d, 32'hA);
`endif
    bus_read(0, d);
    check("sweep_ctrl", d, 32'h08);
    check("sweep_irq", 32'(irq_cnt - irq_base), 32'd1);

    // Channel 2 never answers: timeout, result kept, sweep still completes
    bus_write(0, 32'h18);
    bus_write(1, 32'hF);
    exp_flags = '0;
    bus_read(1, d);
    check("w1c_flags", d, 32'd0);
    rsp_data[0] = 16'h1000; rsp_data[1] = 16'hA000; rsp_data[2] = 16'h7770; rsp_data[3] = 16'h5550;
    mute = 4'b0100;
    irq_base = irq_cnt;
    den_base = den_cnt;
    push_sweep();
    bus_write(0, 32'h1);
    wait_idle("tmo", 3000);
    bus_read(0, d);
    check("tmo_ctrl", d, 32'h18);
    check_regs("tmo");
    check("tmo_gap", 32'(first_den[3] - first_den[2]), 32'd256);
    check("tmo_dens", 32'(den_cnt - den_base), 32'(3 * NRD + 1));
    check("tmo_irq", 32'(irq_cnt - irq_base), 32'd1);
`ifdef XADC_AVG_EN
    bus_read(2 + N_CH, d);
    check("avg_res0", d, 32'h101);
`endif
    mute = '0;

    // Continuous mode: one sweep per eos pulse, extra pulse while busy ignored
    bus_write(0, 32'h1A);
    irq_base = irq_cnt;
    den_base = den_cnt;
    for (int i = 0; i < 3; i++) begin
      push_sweep();
      eos_pulse();
      if (i == 0) begin
        repeat (8) @(negedge clk);
        eos_pulse();
      end
      repeat (90) @(negedge clk);
    end
    wait_idle("cont", 400);
    check("cont_irq", 32'(irq_cnt - irq_base), 32'd3);
    check("cont_dens", 32'(den_cnt - den_base), 32'(3 * N_CH * NRD));
    check_regs("cont");

    // cont cleared mid-sweep: sweep finishes, later eos does nothing
    den_base = den_cnt;
    push_sweep();
    eos_pulse();
    repeat (2) @(negedge clk);
    bus_write(0, 32'h0);
    wait_idle("contoff", 400);
    repeat (10) @(negedge clk);
    eos_pulse();
    repeat (120) @(negedge clk);
    check("contoff_dens", 32'(den_cnt - den_base), 32'(N_CH * NRD));
    bus_read(0, d);
    check("contoff_ctrl", d, 32'h08);

    // W1C of flag0 on the same cycle it is set; start while busy ignored
    bus_write(1, 32'hF);
    exp_flags = '0;
    write_thr(0, 12'h000);
    rsp_data[0] = 16'h1230; rsp_data[1] = 16'h9000; rsp_data[2] = 16'h0010; rsp_data[3] = 16'hFFF0;
    irq_base = irq_cnt;
    den_base = den_cnt;
    push_sweep();
    bus_write(0, 32'h1);
    repeat (4 * NRD - 1) @(negedge clk);
    bus_write(1, 32'h1);
    bus_write(0, 32'h1);
    wait_idle("w1c", 400);
    repeat (20) @(negedge clk);
    bus_read(1, d);
    check("w1c_set_wins", 32'(d[0]), 32'd1);
    check_regs("w1c");
    check("busy_start_dens", 32'(den_cnt - den_base), 32'(N_CH * NRD));
    check("busy_start_irq", 32'(irq_cnt - irq_base), 32'd1);

    // Asynchronous reset while a request is outstanding
    mute = 4'b0001;
    exp_addr_q.push_back(BASE);
    bus_write(0, 32'h1);
    @(negedge clk);
    check("pre_rst_den", 32'(drp_den), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_den", 32'(drp_den), 32'd0);
    check("async_daddr", 32'(drp_daddr), 32'h12);
    for (int c = 0; c < N_CH; c++) begin
      thr_m[c] = '1; exp_result[c] = '0;
    end
    exp_flags = '0;
    bus_read(0, d);
    check("async_ctrl", d, 32'd0);
    bus_read(2, d);
    check("async_thr0", d, 32'hFFF);
    check_regs("async");
    @(negedge clk);
    rst = 1'b1;
    mute = '0;
    den_base = den_cnt;
    repeat (30) @(negedge clk);
    check("post_rst_dens", 32'(den_cnt - den_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
